// File: rtl/branch_resolve.sv
// Memory-stage branch resolver and EX/MEM branch latch.
// Samples beq/bne outcome from EX and issues a one-cycle registered redirect
// (MEM_bpc / MEM_PCSrc). While the redirect is up, it squashes the three
// wrong-path instructions in IF/ID, ID/EX and EX. It also keeps saturating
// taken and not-taken branch counters.

module branch_resolve #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             EX_valid,
  input  logic             EX_branch,
  input  logic             EX_bne,
  input  logic             EX_zero,
  input  logic [31:0]      EX_npc,
  input  logic [31:0]      EX_imm,
  output logic [31:0]      MEM_bpc,
  output logic             MEM_PCSrc,
  output logic             flush_if,
  output logic             flush_id,
  output logic             flush_ex,
  output logic [CNT_W-1:0] taken_cnt,
  output logic [CNT_W-1:0] ntaken_cnt
);

  typedef enum logic [0:0] {StIdle, StRedirect} state_e;

  state_e           state_q;
  logic [31:0]      bpc_q;
  logic [CNT_W-1:0] taken_q;
  logic [CNT_W-1:0] ntaken_q;

  logic        qual;
  logic        cond;
  logic [31:0] target;

  // Offset bits above the 30 that survive the word shift are dropped.
  logic unused_imm_hi;
  assign unused_imm_hi = ^EX_imm[31:30];

  // The EX instruction in a redirect cycle is on the wrong path, so it is ignored.
  assign qual   = EX_valid & EX_branch & (state_q == StIdle);
  assign cond   = EX_bne ? ~EX_zero : EX_zero;
  assign target = EX_npc + {EX_imm[29:0], 2'b00};

  // Redirect FSM: one-cycle REDIRECT per taken branch, target latched on entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      bpc_q   <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (qual && cond) begin
            state_q <= StRedirect;
            bpc_q   <= target;
          end
        end
        StRedirect: state_q <= StIdle;
        default:    state_q <= StIdle;
      endcase
    end
  end

  // Saturating branch statistics; squashed, invalid and non-branch slots count nothing.
  always_ff @(posedge clk) begin
    if (rst) begin
      taken_q  <= '0;
      ntaken_q <= '0;
    end else begin
      if (qual && cond && (taken_q != {CNT_W{1'b1}})) begin
        taken_q <= taken_q + CNT_W'(1);
      end
      if (qual && !cond && (ntaken_q != {CNT_W{1'b1}})) begin
        ntaken_q <= ntaken_q + CNT_W'(1);
      end
    end
  end

  // Flushes are plain decodes of the state register: no EX input reaches an output.
  assign MEM_PCSrc  = (state_q == StRedirect);
  assign MEM_bpc    = bpc_q;
  assign flush_if   = MEM_PCSrc;
  assign flush_id   = MEM_PCSrc;
  assign flush_ex   = MEM_PCSrc;
  assign taken_cnt  = taken_q;
  assign ntaken_cnt = ntaken_q;

endmodule

// File: tb/tb_branch_resolve.sv
// Scoreboard bench for branch_resolve (CNT_W = 4 so saturation is reachable).
// The stimulus side pushes hand-computed expected outputs tagged with the cycle
// in which they must appear; a negedge monitor pops and compares them.

module tb_branch_resolve;

  logic        clk = 1'b0;
  logic        rst;
  logic        EX_valid, EX_branch, EX_bne, EX_zero;
  logic [31:0] EX_npc, EX_imm;
  logic [31:0] MEM_bpc;
  logic        MEM_PCSrc, flush_if, flush_id, flush_ex;
  logic [3:0]  taken_cnt, ntaken_cnt;

  branch_resolve #(.CNT_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .EX_valid  (EX_valid),
    .EX_branch (EX_branch),
    .EX_bne    (EX_bne),
    .EX_zero   (EX_zero),
    .EX_npc    (EX_npc),
    .EX_imm    (EX_imm),
    .MEM_bpc   (MEM_bpc),
    .MEM_PCSrc (MEM_PCSrc),
    .flush_if  (flush_if),
    .flush_id  (flush_id),
    .flush_ex  (flush_ex),
    .taken_cnt (taken_cnt),
    .ntaken_cnt(ntaken_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic        pc;
    logic        chk_b;
    logic [31:0] bpc;
    int          t;
    int          n;
    string       nm;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  // Monitor: compare every expectation due in the current cycle.
  always @(negedge clk) begin
    while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
      exp_t e;
      e = exp_q.pop_front();
      if (e.cyc != cyc) begin
        chk({e.nm, ".missed_cycle"}, cyc, e.cyc);
      end else begin
        chk({e.nm, ".PCSrc"},    {31'd0, MEM_PCSrc}, {31'd0, e.pc});
        chk({e.nm, ".flush_if"}, {31'd0, flush_if},  {31'd0, e.pc});
        chk({e.nm, ".flush_id"}, {31'd0, flush_id},  {31'd0, e.pc});
        chk({e.nm, ".flush_ex"}, {31'd0, flush_ex},  {31'd0, e.pc});
        if (e.chk_b) chk({e.nm, ".bpc"}, MEM_bpc, e.bpc);
        chk({e.nm, ".taken"},  {28'd0, taken_cnt},  e.t);
        chk({e.nm, ".ntaken"}, {28'd0, ntaken_cnt}, e.n);
      end
    end
  end

  // Drive one cycle of EX inputs and queue the outputs required after the next edge.
  task automatic step(input logic r, input logic v, input logic b, input logic bne,
                      input logic z, input logic [31:0] npc, input logic [31:0] imm,
                      input logic e_pc, input logic e_chk, input logic [31:0] e_bpc,
                      input int e_t, input int e_n, input string nm);
    exp_t e;
    rst = r; EX_valid = v; EX_branch = b; EX_bne = bne; EX_zero = z;
    EX_npc = npc; EX_imm = imm;
    e.cyc = cyc + 1; e.pc = e_pc; e.chk_b = e_chk; e.bpc = e_bpc;
    e.t = e_t; e.n = e_n; e.nm = nm;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic [31:0] e_bpc, input int e_t, input int e_n,
                      input string nm);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, e_bpc, e_t, e_n, nm);
  endtask

  initial begin
    int tk;
    rst = 1'b1; EX_valid = 1'b1; EX_branch = 1'b1; EX_bne = 1'b0; EX_zero = 1'b1;
    EX_npc = 32'h104; EX_imm = 32'h3;
    #1;

    // Reset with a taken branch presented: nothing may redirect or count.
    step(1, 1, 1, 0, 1, 32'h104, 32'h3, 0, 1, 32'h0, 0, 0, "reset0");
    step(1, 1, 1, 0, 1, 32'h104, 32'h3, 0, 1, 32'h0, 0, 0, "reset1");

    // Taken beq: 0x104 + 3*4 = 0x110.
    step(0, 1, 1, 0, 1, 32'h104, 32'h3, 1, 1, 32'h110, 1, 0, "beq_taken");
    idle(32'h110, 1, 0, "beq_after");

    // Backward bne: 0x4 + 0xFFFFFFF8 wraps to 0xFFFFFFFC.
    step(0, 1, 1, 1, 0, 32'h4, 32'hFFFF_FFFE, 1, 1, 32'hFFFF_FFFC, 2, 0, "bne_wrap");
    idle(32'hFFFF_FFFC, 2, 0, "bne_after");
    step(0, 1, 1, 1, 1, 32'h4, 32'hFFFF_FFFE, 0, 1, 32'hFFFF_FFFC, 2, 1, "bne_ntaken");

    // Shadow squash: second taken branch during REDIRECT is ignored.
    step(0, 1, 1, 0, 1, 32'h200, 32'h10, 1, 1, 32'h240, 3, 1, "shadow_first");
    step(0, 1, 1, 0, 1, 32'h300, 32'h4, 0, 1, 32'h240, 3, 1, "shadow_second");

    // Invalid slot, then non-branch with zero set.
    step(0, 0, 1, 0, 1, 32'h500, 32'h8, 0, 1, 32'h240, 3, 1, "invalid");
    step(0, 1, 0, 0, 1, 32'h600, 32'h8, 0, 1, 32'h240, 3, 1, "nonbranch");

    // Saturation: clear counters, then 17 taken branches with an idle gap.
    step(1, 0, 0, 0, 0, 32'h0, 32'h0, 0, 1, 32'h0, 0, 0, "sat_reset");
    for (int i = 1; i <= 17; i++) begin
      tk = (i > 15) ? 15 : i;
      step(0, 1, 1, 0, 1, 32'h1000 + 32'(i * 16), 32'(i), 1, 1,
           32'h1000 + 32'(i * 20), tk, 0, $sformatf("sat_br%0d", i));
      idle(32'h1000 + 32'(i * 20), tk, 0, $sformatf("sat_gap%0d", i));
    end

    // Reset asserted during REDIRECT cancels it and clears everything.
    step(0, 1, 1, 0, 1, 32'h2000, 32'h1, 1, 1, 32'h2004, 15, 0, "mid_br");
    step(1, 1, 1, 0, 1, 32'h3000, 32'h1, 0, 1, 32'h0, 0, 0, "mid_reset");
    idle(32'h0, 0, 0, "post_reset");
    step(0, 1, 1, 1, 0, 32'h40, 32'h2, 1, 1, 32'h48, 1, 0, "recover");
    idle(32'h48, 1, 0, "final_idle");

    // Let the monitor drain, bounded.
    for (int k = 0; k < 20 && exp_q.size() > 0; k++) @(posedge clk);
    #1;
    chk("queue_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
